// File: rtl/proc_ctrl_if.sv
// Bus-processor control interface: run/data inputs toward the controller and the
// IR strobe, bus-source selects, load enables and debug state coming back out.
interface proc_ctrl_if;
  logic        run;
  logic [15:0] din;
  logic        ir_in;
  logic [0:7]  rout;     // rout[0] selects R0
  logic        gout;
  logic        din_out;
  logic [0:7]  rin;      // rin[0] loads R0
  logic        ain;
  logic        gin;
  logic        add_sub;
  logic        done;
  logic [1:0]  state;
  logic [8:0]  ir;

  modport master (
    input  run, din,
    output ir_in, rout, gout, din_out, rin, ain, gin, add_sub, done, state, ir
  );

  modport slave (
    output run, din,
    input  ir_in, rout, gout, din_out, rin, ain, gin, add_sub, done, state, ir
  );
endinterface

// File: rtl/proc_ctrl.sv
// Control FSM for the 16-bit bus processor: fetches a 9-bit instruction into IR
// and sequences bus-source selects and load enables over steps T0..T3.
module proc_ctrl #(
  parameter int IW = 9
) (
  input  logic          clk_i,
  input  logic          reset_i,
  proc_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011
  } opcode_e;

  step_e         state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [2:0]    opcode;
  logic [2:0]    reg_x;
  logic [2:0]    reg_y;

  assign opcode = ir_q[IW-1 -: 3];
  assign reg_x  = ir_q[IW-4 -: 3];
  assign reg_y  = ir_q[IW-7 -: 3];

  // Index 0 is the leftmost bit, so R0 maps to the MSB of the select vector.
  function automatic logic [0:7] reg_sel(input logic [2:0] idx);
    logic [0:7] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // NOTE: every output and next-state value gets a default before the case so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    bus.ir_in   = 1'b0;
    bus.rout    = '0;
    bus.gout    = 1'b0;
    bus.din_out = 1'b0;
    bus.rin     = '0;
    bus.ain     = 1'b0;
    bus.gin     = 1'b0;
    bus.add_sub = 1'b0;
    bus.done    = 1'b0;

    unique case (state_q)
      T0: begin
        if (bus.run) begin
          bus.ir_in = 1'b1;
          ir_d      = bus.din[15 -: IW];
          state_d   = T1;
        end
      end
      T1: begin
        unique case (opcode)
          OP_MV: begin
            bus.rout = reg_sel(reg_y);
            bus.rin  = reg_sel(reg_x);
            bus.done = 1'b1;
            state_d  = T0;
          end
          OP_MVI: begin
            bus.din_out = 1'b1;
            bus.rin     = reg_sel(reg_x);
            bus.done    = 1'b1;
            state_d     = T0;
          end
          OP_ADD, OP_SUB: begin
            bus.rout = reg_sel(reg_x);
            bus.ain  = 1'b1;
            state_d  = T2;
          end
          default: begin
            // Undefined opcodes retire as a NOP.
            bus.done = 1'b1;
            state_d  = T0;
          end
        endcase
      end
      T2: begin
        bus.rout    = reg_sel(reg_y);
        bus.gin     = 1'b1;
        bus.add_sub = opcode[0];
        state_d     = T3;
      end
      T3: begin
        bus.gout = 1'b1;
        bus.rin  = reg_sel(reg_x);
        bus.done = 1'b1;
        state_d  = T0;
      end
      default: state_d = T0;
    endcase
  end

  assign bus.state = state_q;
  assign bus.ir    = ir_q;

endmodule

// File: tb/tb_proc_ctrl.sv
// Self-checking bench for proc_ctrl: a per-cycle scoreboard of expected control
// outputs built from an instruction-level model and compared on the falling edge.
module tb_proc_ctrl;

  typedef struct {
    logic [1:0] state;
    logic       ir_in;
    logic [7:0] rout;
    logic       gout;
    logic       din_out;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic       add_sub;
    logic       done;
    logic [8:0] ir;
  } exp_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  int   n_total = 0;
  int   n_bad = 0;
  logic [8:0] ir_m = '0;
  exp_t exp_q[$];

  proc_ctrl_if bus_if ();

  proc_ctrl #(.IW(9)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Bus-source and register-load one-hot invariants, every cycle outside reset.
  always @(negedge clk) begin
    if (!reset_i) begin
      assert (($countones({bus_if.rout, bus_if.gout, bus_if.din_out}) <= 1) &&
              ($countones(bus_if.rin) <= 1))
      else begin
        n_bad++;
        $display("FAIL onehot: rout=%b gout=%b din_out=%b rin=%b",
                 bus_if.rout, bus_if.gout, bus_if.din_out, bus_if.rin);
      end
    end
  end

  function automatic logic [7:0] oh(input logic [2:0] n);
    return 8'h80 >> n;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.state = 2'd0; e.ir_in = 1'b0; e.rout = '0; e.gout = 1'b0; e.din_out = 1'b0;
    e.rin = '0; e.ain = 1'b0; e.gin = 1'b0; e.add_sub = 1'b0; e.done = 1'b0;
    e.ir = ir_m;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    check("state",   {14'd0, bus_if.state},   {14'd0, e.state});
    check("ir_in",   {15'd0, bus_if.ir_in},   {15'd0, e.ir_in});
    check("rout",    {8'd0,  bus_if.rout},    {8'd0,  e.rout});
    check("gout",    {15'd0, bus_if.gout},    {15'd0, e.gout});
    check("din_out", {15'd0, bus_if.din_out}, {15'd0, e.din_out});
    check("rin",     {8'd0,  bus_if.rin},     {8'd0,  e.rin});
    check("ain",     {15'd0, bus_if.ain},     {15'd0, e.ain});
    check("gin",     {15'd0, bus_if.gin},     {15'd0, e.gin});
    check("add_sub", {15'd0, bus_if.add_sub}, {15'd0, e.add_sub});
    check("done",    {15'd0, bus_if.done},    {15'd0, e.done});
    check("ir",      {7'd0,  bus_if.ir},      {7'd0,  e.ir});
  endtask

  // One clock: drive inputs just after the edge, queue the expectation, and
  // compare against the DUT's decode at the falling edge.
  task automatic step(input logic rst, input logic run, input logic [15:0] din, input exp_t e);
    exp_t got_e;
    @(posedge clk);
    #1;
    reset_i     = rst;
    bus_if.run  = run;
    bus_if.din  = din;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("queue_empty", 16'd1, 16'd0);
    end else begin
      got_e = exp_q.pop_front();
      compare(got_e);
    end
  endtask

  // Model one instruction from fetch to retirement; optionally reset in T2.
  task automatic do_instr(input logic [15:0] w, input logic [15:0] imm, input bit abort_t2);
    exp_t e;
    logic [2:0] op, x, y;
    e = idle_exp();
    e.ir_in = 1'b1;
    step(1'b0, 1'b1, w, e);
    ir_m = w[15:7];
    op = ir_m[8:6];
    x  = ir_m[5:3];
    y  = ir_m[2:0];

    e = idle_exp();
    e.state = 2'd1;
    case (op)
      3'b000: begin e.rout = oh(y); e.rin = oh(x); e.done = 1'b1; end
      3'b001: begin e.din_out = 1'b1; e.rin = oh(x); e.done = 1'b1; end
      3'b010, 3'b011: begin e.rout = oh(x); e.ain = 1'b1; end
      default: e.done = 1'b1;
    endcase
    step(1'b0, 1'b1, (op == 3'b001) ? imm : w, e);

    if (op == 3'b010 || op == 3'b011) begin
      e = idle_exp();
      e.state = 2'd2; e.rout = oh(y); e.gin = 1'b1; e.add_sub = op[0];
      step(abort_t2, 1'b1, w, e);
      if (abort_t2) begin
        ir_m = '0;
        step(1'b0, 1'b0, w, idle_exp());
        return;
      end
      e = idle_exp();
      e.state = 2'd3; e.gout = 1'b1; e.rin = oh(x); e.done = 1'b1;
      step(1'b0, 1'b1, w, e);
    end
  endtask

  initial begin
    bus_if.run = 1'b0;
    bus_if.din = '0;

    step(1'b1, 1'b0, 16'h0000, idle_exp());
    step(1'b1, 1'b0, 16'h0000, idle_exp());
    step(1'b0, 1'b0, 16'hFFFF, idle_exp());

    do_instr(16'h2000, 16'h0005, 1'b0);   // mvi R0,#5
    do_instr(16'h0400, 16'h0000, 1'b0);   // mv R1,R0
    do_instr(16'h4880, 16'h0000, 1'b0);   // add R2,R1
    do_instr(16'h6D00, 16'h0000, 1'b0);   // sub R3,R2
    do_instr(16'h2000, 16'h1234, 1'b0);   // mvi then add back-to-back
    do_instr(16'h4880, 16'h0000, 1'b0);
    do_instr(16'h1680, 16'h0000, 1'b0);   // mv R5,R5
    do_instr(16'h8000, 16'h0000, 1'b0);   // undefined opcode
    do_instr(16'hE3C0, 16'h0000, 1'b0);   // undefined opcode, other bits set
    do_instr(16'h4880, 16'h0000, 1'b1);   // add aborted by reset in T2
    do_instr(16'h3C00, 16'hBEEF, 1'b0);   // mvi R7
    do_instr(16'h7E00, 16'h0000, 1'b0);   // sub R7,R4
    step(1'b0, 1'b0, 16'h0000, idle_exp());
    step(1'b0, 1'b0, 16'h0000, idle_exp());

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
